fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-register PC fetch stage. It issues pipelined reads on a valid/ready request channel, buffers up to DEPTH instructions with their PCs, and presents them in order to decode through a valid/ready handshake. Redirects from execute flush the queue and silently discard responses to in-flight stale requests. It sits between the instruction read channel and the decode stage of the core.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: pipelined requests on a valid/ready read channel,
// in-order buffering of {PC, INSTR}, and stale-response dropping after redirect.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CORE_STALL,
    output logic            RCH_REQ_VALID,
    input  logic            RCH_REQ_READY,
    output logic [XLEN-1:0] RCH_ADDR,
    input  logic            RCH_RESP_VALID,
    input  logic [ILEN-1:0] RCH_DATA,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_PC,
    output logic            FETCH_VALID,
    input  logic            FETCH_READY,
    output logic [ILEN-1:0] FETCH_INSTR,
    output logic [XLEN-1:0] FETCH_PC,
    output logic            SPURIOUS_RESP
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   fill;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   drop_cnt;
    logic [PW-1:0]   drop_next;
    logic [PW-1:0]   count;
    logic [PW-1:0]   inflight;
    logic            spurious;
    logic            req_fire;
    logic            pop;
    logic            resp_drop;
    logic            resp_fill;
    logic            resp_spur;

    assign count    = tail - head;
    assign inflight = tail - fill;

    assign RCH_REQ_VALID = !RST && !CORE_STALL && !REDIRECT
                           && (drop_cnt == '0) && (count < PW'(DEPTH));
    assign RCH_ADDR      = fetch_pc;
    assign req_fire      = RCH_REQ_VALID && RCH_REQ_READY;

    assign FETCH_VALID   = !REDIRECT && (fill != head);
    assign FETCH_INSTR   = instr_mem[head[AW-1:0]];
    assign FETCH_PC      = pc_mem[head[AW-1:0]];
    assign pop           = FETCH_VALID && FETCH_READY;
    assign SPURIOUS_RESP = spurious;

    assign resp_drop = RCH_RESP_VALID && (drop_cnt != '0);
    assign resp_fill = RCH_RESP_VALID && (drop_cnt == '0) && (inflight != '0);
    assign resp_spur = RCH_RESP_VALID && (drop_cnt == '0) && (inflight == '0);

    // On redirect every outstanding request becomes stale; a response landing
    // in the same cycle already retires one of them.
    always_comb begin
        drop_next = drop_cnt - PW'(resp_drop);
        if (REDIRECT) begin
            drop_next = drop_cnt + inflight - PW'(resp_drop || resp_fill);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            drop_cnt <= '0;
            spurious <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            drop_cnt <= drop_next;
            if (resp_spur) begin
                spurious <= 1'b1;
            end
            if (REDIRECT) begin
                head     <= '0;
                fill     <= '0;
                tail     <= '0;
                fetch_pc <= REDIRECT_PC;
            end else begin
                if (req_fire) begin
                    pc_mem[tail[AW-1:0]] <= fetch_pc;
                    tail                 <= tail + PW'(1);
                    fetch_pc             <= fetch_pc + XLEN'(4);
                end
                if (resp_fill) begin
                    instr_mem[fill[AW-1:0]] <= RCH_DATA;
                    fill                    <= fill + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table for streaming/stall behaviour,
// hand-written sequences for full queue, redirects and spurious responses.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CORE_STALL = 1'b0;
    logic        RCH_REQ_VALID;
    logic        RCH_REQ_READY = 1'b1;
    logic [31:0] RCH_ADDR;
    logic        RCH_RESP_VALID;
    logic [31:0] RCH_DATA;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        FETCH_VALID;
    logic        FETCH_READY = 1'b0;
    logic [31:0] FETCH_INSTR;
    logic [31:0] FETCH_PC;
    logic        SPURIOUS_RESP;

    fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RST(RST), .CORE_STALL(CORE_STALL),
        .RCH_REQ_VALID(RCH_REQ_VALID), .RCH_REQ_READY(RCH_REQ_READY),
        .RCH_ADDR(RCH_ADDR), .RCH_RESP_VALID(RCH_RESP_VALID), .RCH_DATA(RCH_DATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .FETCH_VALID(FETCH_VALID), .FETCH_READY(FETCH_READY),
        .FETCH_INSTR(FETCH_INSTR), .FETCH_PC(FETCH_PC),
        .SPURIOUS_RESP(SPURIOUS_RESP)
    );

    always #5 CLK = ~CLK;

    // Fixed-latency in-order memory returning the request address as data.
    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    mreq_t       mq[$];
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;

    initial begin
        mreq_t m;
        RCH_RESP_VALID = 1'b0;
        RCH_DATA       = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                mq.delete();
            end else if (RCH_REQ_VALID && RCH_REQ_READY) begin
                m.addr = RCH_ADDR;
                m.due  = cyc + mem_lat;
                mq.push_back(m);
            end
            @(posedge CLK);
            cyc++;
            #1;
            if (!RST && mq.size() > 0 && mq[0].due <= cyc) begin
                RCH_RESP_VALID = 1'b1;
                RCH_DATA       = mq[0].addr;
                void'(mq.pop_front());
            end else begin
                RCH_RESP_VALID = 1'b0;
                RCH_DATA       = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n_acc = 0;
    logic [31:0] pops_pc[$];
    logic [31:0] pops_in[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic sample();
        if (FETCH_VALID && FETCH_READY) begin
            pops_pc.push_back(FETCH_PC);
            pops_in.push_back(FETCH_INSTR);
        end
        if (RCH_REQ_VALID && RCH_REQ_READY) n_acc++;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge CLK);
            sample();
            tick();
        end
    endtask

    // Leaves the caller at the start of the first cycle after reset release.
    task automatic do_reset();
        RST = 1'b1; CORE_STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
        RCH_REQ_READY = 1'b1; FETCH_READY = 1'b0;
        repeat (3) tick();
        @(negedge CLK);
        check("rst_req_valid", 32'(RCH_REQ_VALID), 32'd0);
        check("rst_addr", RCH_ADDR, 32'h0);
        check("rst_fetch_valid", 32'(FETCH_VALID), 32'd0);
        check("rst_fetch_pc", FETCH_PC, 32'h0);
        check("rst_fetch_instr", FETCH_INSTR, 32'h0);
        check("rst_spurious", 32'(SPURIOUS_RESP), 32'd0);
        tick();
        RST = 1'b0;
        n_acc = 0;
        pops_pc.delete();
        pops_in.delete();
    endtask

    task automatic check_pops(input string name, input logic [31:0] base, input int unsigned min_n);
        check({name, "_count_ok"}, 32'(pops_pc.size() >= min_n), 32'd1);
        for (int i = 0; i < pops_pc.size(); i++) begin
            check({name, "_pc"}, pops_pc[i], base + 32'(4 * i));
            check({name, "_instr"}, pops_in[i], base + 32'(4 * i));
        end
    endtask

    typedef struct {
        logic        stall;
        logic        fready;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_fv;
        logic [31:0] exp_fpc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int unsigned waited;

        // Cycle 1 is the first cycle after reset release; 1-cycle memory.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h14};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b0, 32'h00};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b0, 32'h00};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h18, 1'b0, 32'h00};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 32'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};

        // Streaming with a 5-cycle stall in the middle.
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            CORE_STALL  = vecs[i].stall;
            FETCH_READY = vecs[i].fready;
            @(negedge CLK);
            check($sformatf("vec%0d_req_valid", i), 32'(RCH_REQ_VALID), 32'(vecs[i].exp_rv));
            check($sformatf("vec%0d_addr", i), RCH_ADDR, vecs[i].exp_addr);
            check($sformatf("vec%0d_fetch_valid", i), 32'(FETCH_VALID), 32'(vecs[i].exp_fv));
            if (vecs[i].exp_fv) begin
                check($sformatf("vec%0d_fetch_pc", i), FETCH_PC, vecs[i].exp_fpc);
                check($sformatf("vec%0d_fetch_instr", i), FETCH_INSTR, vecs[i].exp_fpc);
            end
            tick();
        end

        // Full queue: reset mid-stream, then decode stalled.
        mem_lat = 1;
        do_reset();
        FETCH_READY = 1'b0;
        run(10);
        check("full_accepted", n_acc, 32'd4);
        @(negedge CLK);
        check("full_req_valid", 32'(RCH_REQ_VALID), 32'd0);
        check("full_fetch_valid", 32'(FETCH_VALID), 32'd1);
        check("full_head_pc", FETCH_PC, 32'h0);
        tick();
        n_acc = 0;
        FETCH_READY = 1'b1;
        @(negedge CLK);
        check("pop_cycle_no_reuse", 32'(RCH_REQ_VALID), 32'd0);
        sample();
        tick();
        FETCH_READY = 1'b0;
        @(negedge CLK);
        check("credit_req_valid", 32'(RCH_REQ_VALID), 32'd1);
        check("credit_addr", RCH_ADDR, 32'h10);
        check("credit_head_pc", FETCH_PC, 32'h4);
        sample();
        tick();
        run(5);
        check("credit_accepted", n_acc, 32'd1);

        // Redirect with three requests in flight on a 4-cycle memory.
        mem_lat = 4;
        do_reset();
        FETCH_READY = 1'b1;
        run(3);
        check("rd1_inflight_setup", n_acc, 32'd3);
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h100;
        @(negedge CLK);
        check("rd1_req_blocked", 32'(RCH_REQ_VALID), 32'd0);
        check("rd1_fetch_valid", 32'(FETCH_VALID), 32'd0);
        sample();
        tick();
        REDIRECT = 1'b0;
        @(negedge CLK);
        check("rd1_addr_next", RCH_ADDR, 32'h100);
        waited = 0;
        while (!RCH_REQ_VALID && waited < 10) begin
            sample();
            tick();
            @(negedge CLK);
            waited++;
        end
        check("rd1_drop_cycles", waited, 32'd3);
        check("rd1_restart_addr", RCH_ADDR, 32'h100);
        sample();
        tick();
        run(16);
        check_pops("rd1", 32'h100, 3);
        check("rd1_spurious", 32'(SPURIOUS_RESP), 32'd0);

        // Redirect coinciding with a response, then a second redirect.
        mem_lat = 3;
        do_reset();
        FETCH_READY = 1'b1;
        run(3);
        check("rd2_resp_coincides", 32'(RCH_RESP_VALID), 32'd1);
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h100;
        run(1);
        REDIRECT = 1'b0;
        run(1);
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h200;
        run(1);
        REDIRECT = 1'b0;
        @(negedge CLK);
        check("rd2_req_valid", 32'(RCH_REQ_VALID), 32'd1);
        check("rd2_addr", RCH_ADDR, 32'h200);
        sample();
        tick();
        run(12);
        check_pops("rd2", 32'h200, 2);
        check("rd2_spurious", 32'(SPURIOUS_RESP), 32'd0);

        // Spurious response with nothing in flight.
        mem_lat = 1;
        do_reset();
        CORE_STALL = 1'b1;
        FETCH_READY = 1'b1;
        run(1);
        RCH_RESP_VALID = 1'b1;
        RCH_DATA = 32'h1234_5678;
        @(negedge CLK);
        check("spur_before", 32'(SPURIOUS_RESP), 32'd0);
        tick();
        @(negedge CLK);
        check("spur_set", 32'(SPURIOUS_RESP), 32'd1);
        check("spur_no_entry", 32'(FETCH_VALID), 32'd0);
        tick();
        run(3);
        @(negedge CLK);
        check("spur_held", 32'(SPURIOUS_RESP), 32'd1);
        check("spur_addr", RCH_ADDR, 32'h0);
        tick();
        CORE_STALL = 1'b0;
        run(6);
        check_pops("spur", 32'h0, 3);
        check("spur_still_held", 32'(SPURIOUS_RESP), 32'd1);
        do_reset();
        @(negedge CLK);
        check("spur_cleared", 32'(SPURIOUS_RESP), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
